// File: rtl/uart_cmd_arbiter_if.sv
// Bundle between the host-side requesters, the arbiter and the UART command
// engine. The arbiter connects through the slave modport. The master modport
// is the view seen by the requesters and the engine.
//   requester side : req_valid/req_cmd/req_ready, rsp_valid/rsp_ready/rsp_data/rsp_status
//   engine side    : m_cmd_valid/m_cmd_data/m_cmd_ready, m_read_valid/m_read_data
//   status         : busy
interface uart_cmd_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int CMD_WIDTH  = 16,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [NUM_REQ-1:0]           rsp_ready;
  logic [DATA_WIDTH-1:0]        rsp_data;
  logic [1:0]                   rsp_status;
  logic                         m_cmd_valid;
  logic [CMD_WIDTH-1:0]         m_cmd_data;
  logic                         m_cmd_ready;
  logic                         m_read_valid;
  logic [DATA_WIDTH-1:0]        m_read_data;
  logic                         busy;

  modport slave (
    input  req_valid, req_cmd, rsp_ready, m_cmd_ready, m_read_valid, m_read_data,
    output req_ready, rsp_valid, rsp_data, rsp_status, m_cmd_valid, m_cmd_data, busy
  );

  modport master (
    output req_valid, req_cmd, rsp_ready, m_cmd_ready, m_read_valid, m_read_data,
    input  req_ready, rsp_valid, rsp_data, rsp_status, m_cmd_valid, m_cmd_data, busy
  );
endinterface

// File: rtl/uart_cmd_arbiter.sv
// Shares the single command port of the UART command engine between NUM_REQ
// requesters. Round-robin grant, one command in flight, and the response
// (read data + status) is routed back to the requester that was granted.
// Read parity failures show up as the engine going idle without a read_valid.
// A response timeout produces status 10 and the engine is then drained.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : uart_cmd_arbiter_if.slave
//                requester handshake (req_*, rsp_*), engine port (m_*), busy
//
// state | meaning
// ARB   | idle, pick the next requester round-robin from ptr+1
// ISSUE | present latched command to the engine until accepted
// WAIT  | command running, capture read data, watch for idle or timeout
// RESP  | hold response to the granted requester until rsp_ready[id]
// DRAIN | after a timeout, wait for the engine to go idle, drop read data
module uart_cmd_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int CMD_WIDTH      = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input logic               clk,
  input logic               rst_n,
  uart_cmd_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_PARITY  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {ARB, ISSUE, WAIT, RESP, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [PTR_W-1:0]      ptr, id_q, winner, cand;
  logic                  found;
  logic [CMD_WIDTH-1:0]  cmd_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [1:0]            status_q;
  logic                  got_data, timed_out, timeout_hit, is_write;
  logic [CNT_W-1:0]      cnt;
  logic [CMD_WIDTH-1:0]  cmd_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cmd
    assign cmd_arr[g] = bus.req_cmd[g*CMD_WIDTH +: CMD_WIDTH];
  end

  assign is_write    = cmd_q[CMD_WIDTH-1];
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus.busy    = (state != ARB);

  // Scan starts one past the last winner so the last winner has lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    bus.req_ready   = '0;
    bus.rsp_valid   = '0;
    bus.rsp_data    = '0;
    bus.rsp_status  = '0;
    bus.m_cmd_valid = 1'b0;
    bus.m_cmd_data  = '0;
    case (state)
      ARB: begin
        if (found) begin
          bus.req_ready[winner] = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        bus.m_cmd_valid = 1'b1;
        bus.m_cmd_data  = cmd_q;
        if (bus.m_cmd_ready) state_nxt = WAIT;
      end
      WAIT: begin
        // A read arriving in the expiry cycle beats the timeout.
        if (bus.m_cmd_ready) state_nxt = RESP;
        else if (timeout_hit && !bus.m_read_valid) state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid[id_q] = 1'b1;
        bus.rsp_data        = data_q;
        bus.rsp_status      = status_q;
        if (bus.rsp_ready[id_q]) state_nxt = timed_out ? DRAIN : ARB;
      end
      DRAIN: begin
        if (bus.m_cmd_ready) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB;
      ptr       <= PTR_W'(NUM_REQ - 1);
      id_q      <= '0;
      cmd_q     <= '0;
      data_q    <= '0;
      status_q  <= ST_OK;
      got_data  <= 1'b0;
      timed_out <= 1'b0;
      cnt       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ARB: begin
          if (found) begin
            ptr   <= winner;
            id_q  <= winner;
            cmd_q <= cmd_arr[winner];
          end
        end
        ISSUE: begin
          if (bus.m_cmd_ready) begin
            cnt       <= '0;
            got_data  <= 1'b0;
            data_q    <= '0;
            timed_out <= 1'b0;
          end
        end
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (bus.m_read_valid) begin
            data_q   <= bus.m_read_data;
            got_data <= 1'b1;
          end
          if (bus.m_cmd_ready) begin
            if (is_write) begin
              status_q <= ST_OK;
              data_q   <= '0;
            end else if (got_data || bus.m_read_valid) begin
              status_q <= ST_OK;
            end else begin
              status_q <= ST_PARITY;
              data_q   <= '0;
            end
          end else if (timeout_hit && !bus.m_read_valid) begin
            status_q  <= ST_TIMEOUT;
            data_q    <= '0;
            timed_out <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_arbiter.sv
module tb_uart_cmd_arbiter;
  localparam int NR = 4;
  localparam int CW = 16;
  localparam int DW = 8;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_arbiter_if #(.NUM_REQ(NR), .CMD_WIDTH(CW), .DATA_WIDTH(DW)) bus ();

  uart_cmd_arbiter #(
    .NUM_REQ(NR), .CMD_WIDTH(CW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    int         id;
    logic [7:0] data;
    logic [1:0] st;
  } rsp_t;

  rsp_t        exp_rsp [$];
  logic [15:0] exp_cmd [$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;

  int         eng_len = 5;
  int         eng_pulse = 0;
  logic [7:0] eng_rdata = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rr_cmd(input int i);
    logic [15:0] c;
    c = 16'h8000 | 16'(i << 8) | 16'(8'h10 + i);
    return c;
  endfunction

  // Engine model: ready while idle, busy eng_len cycles after an accept,
  // optional one-cycle read_valid at busy cycle eng_pulse.
  initial begin
    int l, p;
    logic [7:0] d;
    bus.m_cmd_ready  = 1'b1;
    bus.m_read_valid = 1'b0;
    bus.m_read_data  = '0;
    forever begin
      @(negedge clk);
      while (bus.m_cmd_valid && bus.m_cmd_ready) begin
        l = eng_len;
        p = eng_pulse;
        d = eng_rdata;
        @(negedge clk);
        bus.m_cmd_ready = 1'b0;
        for (int i = 1; i <= l; i++) begin
          @(negedge clk);
          bus.m_read_valid = (i == p);
          bus.m_read_data  = (i == p) ? d : 8'h00;
        end
        @(negedge clk);
        bus.m_read_valid = 1'b0;
        bus.m_read_data  = 8'h00;
        bus.m_cmd_ready  = 1'b1;
      end
    end
  end

  // Scoreboard: commands checked on engine accept, responses on handshake.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (bus.m_cmd_valid && bus.m_cmd_ready) begin
          acc_cyc = cyc;
          if (exp_cmd.size() == 0) chk("cmd_unexpected", 32'(bus.m_cmd_data), 32'hFFFF_FFFF);
          else chk("cmd_data", 32'(bus.m_cmd_data), 32'(exp_cmd.pop_front()));
        end
        if ((bus.rsp_valid & bus.rsp_ready) != 0) begin
          if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
          else begin
            r = exp_rsp.pop_front();
            chk("rsp_id", 32'(bus.rsp_valid), 32'(1) << r.id);
            chk("rsp_data", 32'(bus.rsp_data), 32'(r.data));
            chk("rsp_status", 32'(bus.rsp_status), 32'(r.st));
          end
        end
      end
    end
  end

  task automatic send(input int id, input logic [15:0] cmd, input logic [7:0] edata,
                      input logic [1:0] est, input bit want_rsp, output logic rdy);
    int n = 0;
    rsp_t r;
    bus.req_cmd[id*CW +: CW] = cmd;
    bus.req_valid[id] = 1'b1;
    exp_cmd.push_back(cmd);
    if (want_rsp) begin
      r.id = id; r.data = edata; r.st = est;
      exp_rsp.push_back(r);
    end
    #1;
    while (bus.req_ready == 0 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    rdy = bus.m_cmd_ready;
    chk("grant", 32'(bus.req_ready), 32'(1) << id);
    @(negedge clk);
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (exp_rsp.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_drain", 32'(exp_rsp.size()), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic       rdy;
    int         n, bad;
    logic [3:0] sv;
    logic [7:0] sd;
    logic [1:0] ss;
    rsp_t       r;

    bus.req_valid = '0;
    bus.req_cmd   = '0;
    bus.rsp_ready = '1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", 32'({bus.busy, bus.req_ready, bus.rsp_valid, bus.m_cmd_valid}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Round robin with all requesters held valid: 0,1,2,3,0,1,2,3.
    eng_len = 3; eng_pulse = 0;
    for (int i = 0; i < NR; i++) bus.req_cmd[i*CW +: CW] = rr_cmd(i);
    for (int k = 0; k < 8; k++) begin
      exp_cmd.push_back(rr_cmd(k % NR));
      r.id = k % NR; r.data = 8'h00; r.st = 2'b00;
      exp_rsp.push_back(r);
    end
    bus.req_valid = '1;
    #1;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (bus.req_ready == 0 && n < 3000) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("rr_grant", 32'(bus.req_ready), 32'(1) << (k % NR));
      @(negedge clk);
      #1;
    end
    bus.req_valid = '0;
    wait_rsp();

    // Write, plain read, read with parity failure.
    eng_len = 10; eng_pulse = 0;
    send(0, 16'h8A55, 8'h00, 2'b00, 1'b1, rdy);
    wait_rsp();
    eng_len = 6; eng_pulse = 3; eng_rdata = 8'hA5;
    send(2, 16'h0300, 8'hA5, 2'b00, 1'b1, rdy);
    wait_rsp();
    eng_len = 4; eng_pulse = 0;
    send(1, 16'h0142, 8'h00, 2'b01, 1'b1, rdy);
    wait_rsp();

    // Read pulse lands in the expiry cycle: the read wins.
    eng_len = 110; eng_pulse = TO - 1; eng_rdata = 8'h77;
    send(2, 16'h0221, 8'h77, 2'b00, 1'b1, rdy);
    wait_rsp();

    // Timeout: engine busy 300 cycles, late read pulse must be discarded.
    eng_len = 300; eng_pulse = 150; eng_rdata = 8'hEE;
    send(3, 16'h0512, 8'h00, 2'b10, 1'b1, rdy);
    n = 0;
    while (bus.rsp_valid == 0 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("timeout_latency", 32'(cyc - acc_cyc - 1), 32'(TO));
    wait_rsp();
    eng_len = 4; eng_pulse = 0;
    send(1, 16'h81C3, 8'h00, 2'b00, 1'b1, rdy);
    chk("drain_gate", 32'(rdy), 32'h1);
    wait_rsp();

    // Response held 20 cycles, other rsp_ready bits high, another request pending.
    bus.rsp_ready = 4'b0111;
    eng_len = 4; eng_pulse = 2; eng_rdata = 8'h3C;
    send(3, 16'h0433, 8'h3C, 2'b00, 1'b1, rdy);
    bus.req_cmd[1*CW +: CW] = 16'h81AA;
    bus.req_valid[1] = 1'b1;
    exp_cmd.push_back(16'h81AA);
    r.id = 1; r.data = 8'h00; r.st = 2'b00;
    exp_rsp.push_back(r);
    n = 0;
    #1;
    while (bus.rsp_valid == 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    sv = bus.rsp_valid; sd = bus.rsp_data; ss = bus.rsp_status;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid !== sv || bus.rsp_data !== sd || bus.rsp_status !== ss ||
          bus.req_ready != 0) bad++;
    end
    chk("hold_rsp_valid", 32'(sv), 32'h8);
    chk("hold_stable", 32'(bad), 32'h0);
    bus.rsp_ready = '1;
    n = 0;
    while (bus.req_ready == 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("grant_after_hold", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    wait_rsp();

    // Reset in the middle of WAIT: response lost, requester 0 wins next.
    eng_len = 50; eng_pulse = 0;
    send(2, 16'h0277, 8'h00, 2'b00, 1'b0, rdy);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", 32'({bus.busy, bus.req_ready, bus.rsp_valid, bus.m_cmd_valid, bus.rsp_status}), 32'h0);
    chk("rst_mid_data", 32'({bus.m_cmd_data, bus.rsp_data}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    eng_len = 5;
    for (int i = 0; i < NR; i++) bus.req_cmd[i*CW +: CW] = 16'h8123 + 16'(i);
    exp_cmd.push_back(16'h8123);
    r.id = 0; r.data = 8'h00; r.st = 2'b00;
    exp_rsp.push_back(r);
    bus.req_valid = '1;
    #1;
    chk("grant_after_reset", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = '0;
    wait_rsp();

    repeat (5) @(negedge clk);
    chk("cmd_queue_empty", 32'(exp_cmd.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
